uart_line_parser: RTL and testbench

- Upstream stage of the parsed-line interrupt PIO. Receives 8N1 serial data on `rxd` and assembles bytes into a line buffer.
- On a CR or LF terminator it raises the level output `line_ready`. That output drives the PIO `in_port`, so the PIO edge-capture logic generates one IRQ per completed line.
- The CPU reads the line through a small registered read port, then releases the buffer with `line_ack`.

---
 rtl/uart_line_parser_pkg.sv | 28 ++
 rtl/uart_line_parser_if.sv | 26 ++
 rtl/uart_line_parser_rx_core.sv | 119 +++++++++++
 rtl/uart_line_parser.sv | 89 ++++++++
 tb/tb_uart_line_parser.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_line_parser_pkg.sv
// Shared types and constants for the UART line parser: receive FSM states,
// line terminator characters and the oversampling divider calculation.
package uart_parser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam int         OVS     = 16;

  // Rounded clocks-per-tick for 16x oversampling, never below 1.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = (clk_hz + (baud * OVS) / 2) / (baud * OVS);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic is_terminator(input logic [7:0] b);
    return (b == CHAR_CR) || (b == CHAR_LF);
  endfunction

endpackage

// File: rtl/uart_line_parser_if.sv
// CPU-facing line buffer port: registered read port, completion level,
// release pulse and sticky error flags.
interface uart_line_if #(
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [AW:0]   line_len;
  logic          line_ready;
  logic          line_ack;
  logic          overflow;
  logic          frame_err;

  modport master (
    output rd_addr, line_ack,
    input  rd_data, line_len, line_ready, overflow, frame_err
  );

  modport slave (
    input  rd_addr, line_ack,
    output rd_data, line_len, line_ready, overflow, frame_err
  );

endinterface

// File: rtl/uart_line_parser_rx_core.sv
// 8N1 receiver: rxd synchronizer, 16x oversampling tick and receive FSM.
// Emits one-clock byte_valid / frame_err_pulse strobes.
module uart_rx_core
  import uart_parser_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err_pulse
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [3:0] HALF_LAST = 4'(OVS / 2 - 1);
  localparam logic [3:0] FULL_LAST = 4'(OVS - 1);

  logic [1:0]    sync;
  logic          rxd_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  rx_state_t     state;
  logic [3:0]    tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  assign rxd_s = sync[1];
  assign tick  = (div_cnt == '0);

  // Synchronizer resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rxd};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= DW'(DIV - 1);
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every branch
  // reads the pre-edge values of state, counters and shift register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      tick_cnt        <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      rx_byte         <= '0;
      byte_valid      <= 1'b0;
      frame_err_pulse <= 1'b0;
    end else begin
      byte_valid      <= 1'b0;
      frame_err_pulse <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rxd_s) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rxd_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rxd_s, shreg[7:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) state <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              if (rxd_s) begin
                rx_byte    <= shreg;
                byte_valid <= 1'b1;
                state      <= IDLE;
              end else begin
                frame_err_pulse <= 1'b1;
                state           <= BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          BREAK: begin
            if (rxd_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_line_parser.sv
// Line assembler: collects received bytes into a buffer until CR/LF, holds
// the completed line for the CPU until line_ack, and tracks sticky errors.
module uart_line_parser
  import uart_parser_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 32
) (
  input logic        clk,
  input logic        reset_n,
  input logic        rxd,
  uart_line_if.slave bus
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic        frame_err_pulse;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic        is_term;
  logic        wr_en;

  uart_rx_core #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx_core (
    .clk             (clk),
    .reset_n         (reset_n),
    .rxd             (rxd),
    .rx_byte         (rx_byte),
    .byte_valid      (byte_valid),
    .frame_err_pulse (frame_err_pulse)
  );

  assign is_term = is_terminator(rx_byte);
  assign wr_en   = byte_valid && !bus.line_ready && !is_term && (wr_ptr != FULL);

  // NOTE: the line buffer has no reset; it is only read behind line_len,
  // and leaving it out of reset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rd_data <= '0;
    end else begin
      bus.rd_data <= mem[bus.rd_addr];
    end
  end

  // Clears from line_ack come first so that any set in the same cycle wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      bus.line_len   <= '0;
      bus.line_ready <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      if (bus.line_ack) begin
        bus.line_ready <= 1'b0;
        bus.overflow   <= 1'b0;
        bus.frame_err  <= 1'b0;
      end
      if (frame_err_pulse) bus.frame_err <= 1'b1;
      if (byte_valid) begin
        if (bus.line_ready) begin
          bus.overflow <= 1'b1;
        end else if (is_term) begin
          if (wr_ptr != '0) begin
            bus.line_len   <= wr_ptr;
            bus.line_ready <= 1'b1;
            wr_ptr         <= '0;
          end
        end else if (wr_ptr == FULL) begin
          bus.overflow <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_line_parser.sv
// Directed and randomized line traffic against a queue-based model of the
// line-assembly rules, with 16 clocks per serial bit.
module tb_uart_line_parser;
  import uart_parser_pkg::*;

  localparam int CLK_HZ   = 1600000;
  localparam int BAUD     = 100000;
  localparam int DEPTH    = 32;
  localparam int BIT_CLKS = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic rxd     = 1'b1;

  uart_line_if #(.DEPTH(DEPTH)) bus ();

  uart_line_parser #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rxd     (rxd),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int   rises    = 0;
  int   rise_cyc = 0;
  logic lr_prev  = 1'b0;
  always @(negedge clk) begin
    if (bus.line_ready === 1'b1 && lr_prev !== 1'b1) begin
      rises++;
      rise_cyc = cyc;
    end
    lr_prev = bus.line_ready;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: the line being assembled and the last completed line.
  logic [7:0] m_line[$];
  logic [7:0] m_done[$];
  int         m_len   = 0;
  logic       m_ready = 1'b0;
  logic       m_ovf   = 1'b0;
  logic       m_ferr  = 1'b0;
  int         frame_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_ready) begin
      m_ovf = 1'b1;
    end else if (b == CHAR_CR || b == CHAR_LF) begin
      if (m_line.size() != 0) begin
        m_done  = m_line;
        m_len   = m_line.size();
        m_ready = 1'b1;
        m_line.delete();
      end
    end else if (m_line.size() == DEPTH) begin
      m_ovf = 1'b1;
    end else begin
      m_line.push_back(b);
    end
  endtask

  task automatic model_reset();
    m_line.delete();
    m_len   = 0;
    m_ready = 1'b0;
    m_ovf   = 1'b0;
    m_ferr  = 1'b0;
  endtask

  // Starts on a falling clock edge; leaves rxd at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    frame_cyc = cyc;
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd = stop;
    repeat (BIT_CLKS) @(negedge clk);
    if (stop) model_byte(b);
    else m_ferr = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_frame(s[i], 1'b1);
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".line_ready"}, bus.line_ready, m_ready);
    check({tag, ".overflow"}, bus.overflow, m_ovf);
    check({tag, ".frame_err"}, bus.frame_err, m_ferr);
  endtask

  task automatic check_line(input string tag);
    check_flags(tag);
    check({tag, ".line_len"}, bus.line_len, m_len);
    for (int i = 0; i < m_len; i++) begin
      bus.rd_addr = i[4:0];
      @(negedge clk);
      check($sformatf("%s.rd_data[%0d]", tag, i), bus.rd_data, m_done[i]);
    end
  endtask

  task automatic do_ack(input string tag);
    bus.line_ack = 1'b1;
    @(negedge clk);
    bus.line_ack = 1'b0;
    m_ready = 1'b0;
    m_ovf   = 1'b0;
    m_ferr  = 1'b0;
    check_flags({tag, ".ack"});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rd_data"}, bus.rd_data, 8'h00);
    check({tag, ".line_len"}, bus.line_len, 0);
    check({tag, ".line_ready"}, bus.line_ready, 1'b0);
    check({tag, ".overflow"}, bus.overflow, 1'b0);
    check({tag, ".frame_err"}, bus.frame_err, 1'b0);
  endtask

  initial begin
    int r0;
    int d;
    int len;
    string s;

    bus.rd_addr  = '0;
    bus.line_ack = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // "AB\n" with completion latency relative to the LF stop bit
    send_str("AB");
    send_frame(CHAR_LF, 1'b1);
    d = rise_cyc - frame_cyc;
    check("ab.latency_window", (d >= 9 * BIT_CLKS + 1 && d <= 9 * BIT_CLKS + 8 + 3 + 2), 1);
    repeat (2) @(negedge clk);
    check_line("ab");
    do_ack("ab");

    // CRLF yields a single line
    r0 = rises;
    send_str("X\r\n");
    check("crlf.rises", rises, r0 + 1);
    check_line("crlf");
    do_ack("crlf");

    // 33 bytes into a 32-byte buffer
    for (int i = 0; i < 33; i++) send_frame(8'h41 + i[7:0], 1'b1);
    send_str("\n");
    check("ovf.len32", bus.line_len, DEPTH);
    check_line("ovf");
    do_ack("ovf");

    // Low stop bit, held break, then a clean line
    send_frame(8'h55, 1'b0);
    repeat (40) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check_flags("ferr");
    send_str("Q\n");
    check_line("ferr_q");
    do_ack("ferr_q");

    // Short glitch must not produce a byte
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch.line_ready", bus.line_ready, 1'b0);
    send_str("K\n");
    check_line("glitch_k");
    do_ack("glitch_k");

    // Reset mid-byte with a partial line pending
    send_str("PP");
    rxd = 1'b0;
    repeat (BIT_CLKS * 3) @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("midreset");
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    send_str("R\n");
    check_line("after_reset");
    do_ack("after_reset");

    // Byte arriving while a line is held is dropped
    send_str("N\n");
    send_str("Z");
    check_line("held_z");
    do_ack("held_z");
    send_str("M\n");
    check_line("m");
    do_ack("m");

    // Randomized lines, some longer than the buffer
    for (int n = 0; n < 3; n++) begin
      len = $urandom_range(1, 36);
      s = "";
      for (int i = 0; i < len; i++) s = {s, string'(8'($urandom_range(8'h20, 8'h7E)))};
      s = {s, ($urandom_range(0, 1) != 0) ? "\r" : "\n"};
      send_str(s);
      check_line($sformatf("rand%0d", n));
      do_ack($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
